// File: rtl/config_pkg.sv
// Minimal CVA6 configuration record.
// Carries only the fields this coprocessor consults.
package config_pkg;

  typedef struct packed {
    int unsigned XLEN;
    int unsigned X_NUM_RS;
    int unsigned X_ID_WIDTH;
  } cva6_cfg_t;

  localparam int unsigned CfgXlen    = 32;
  localparam int unsigned CfgNumRs   = 3;
  localparam int unsigned CfgIdWidth = 4;

  localparam cva6_cfg_t cva6_cfg_empty = '{
    XLEN:       CfgXlen,
    X_NUM_RS:   CfgNumRs,
    X_ID_WIDTH: CfgIdWidth
  };

endpackage

// File: rtl/cvxif_pkg.sv
// CORE-V-XIF request/response bundles between the CVA6 core and a coprocessor.
// Widths follow the default configuration record.
package cvxif_pkg;

  localparam int unsigned XLEN       = config_pkg::CfgXlen;
  localparam int unsigned X_NUM_RS   = config_pkg::CfgNumRs;
  localparam int unsigned X_ID_WIDTH = config_pkg::CfgIdWidth;

  typedef struct packed {
    logic [31:0]                   instr;
    logic [1:0]                    mode;
    logic [X_ID_WIDTH-1:0]         id;
    logic [X_NUM_RS-1:0][XLEN-1:0] rs;
    logic [X_NUM_RS-1:0]           rs_valid;
  } x_issue_req_t;

  typedef struct packed {
    logic accept;
    logic writeback;
    logic dualwrite;
    logic dualread;
    logic loadstore;
    logic exc;
  } x_issue_resp_t;

  typedef struct packed {
    logic [X_ID_WIDTH-1:0] id;
    logic                  x_commit_kill;
  } x_commit_t;

  typedef struct packed {
    logic [X_ID_WIDTH-1:0] id;
    logic [31:0]           addr;
    logic [1:0]            mode;
    logic                  we;
    logic [1:0]            size;
    logic [XLEN-1:0]       wdata;
    logic                  last;
    logic                  spec;
  } x_mem_req_t;

  typedef struct packed {
    logic       exc;
    logic [5:0] exccode;
  } x_mem_resp_t;

  typedef struct packed {
    logic [X_ID_WIDTH-1:0] id;
    logic [XLEN-1:0]       rdata;
    logic                  err;
  } x_mem_result_t;

  typedef struct packed {
    logic [X_ID_WIDTH-1:0] id;
    logic [XLEN-1:0]       data;
    logic [4:0]            rd;
    logic                  we;
    logic                  exc;
    logic [5:0]            exccode;
  } x_result_t;

  typedef struct packed {
    logic          x_issue_valid;
    x_issue_req_t  x_issue_req;
    logic          x_commit_valid;
    x_commit_t     x_commit;
    logic          x_mem_ready;
    x_mem_resp_t   x_mem_resp;
    logic          x_mem_result_valid;
    x_mem_result_t x_mem_result;
    logic          x_result_ready;
  } cvxif_req_t;

  typedef struct packed {
    logic          x_issue_ready;
    x_issue_resp_t x_issue_resp;
    logic          x_mem_valid;
    x_mem_req_t    x_mem_req;
    logic          x_result_valid;
    x_result_t     x_result;
  } cvxif_resp_t;

endpackage

// File: rtl/cvxif_copro_resp.sv
// CV-X-IF coprocessor for custom-0 ADD/SUB/XOR/ADD3/TRAP: operand register, then result FIFO
// (result visible 2 cycles after issue); issue-ready drops once Depth entries are in flight.
module cvxif_copro_resp #(
  parameter config_pkg::cva6_cfg_t CVA6Cfg = config_pkg::cva6_cfg_empty,
  parameter int unsigned           Depth   = 4
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  cvxif_pkg::cvxif_req_t  cvxif_req_i,
  output cvxif_pkg::cvxif_resp_t cvxif_resp_o
);

  localparam int unsigned XLEN = cvxif_pkg::XLEN;
  localparam int unsigned IDW  = cvxif_pkg::X_ID_WIDTH;
  localparam int unsigned NRS  = cvxif_pkg::X_NUM_RS;
  localparam int unsigned AW   = $clog2(Depth);
  localparam int unsigned OW   = AW + 2;

  localparam logic [6:0] OPC_CUSTOM0 = 7'b0001011;
  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SUB  = 3'b001;
  localparam logic [2:0] F3_XOR  = 3'b010;
  localparam logic [2:0] F3_ADD3 = 3'b011;
  localparam logic [2:0] F3_TRAP = 3'b111;

  typedef struct packed {
    logic [IDW-1:0]  id;
    logic [4:0]      rd;
    logic            we;
    logic            trap;
    logic            cmt;
    logic            kill;
    logic [XLEN-1:0] data;
  } entry_t;

  function automatic entry_t f_commit(input entry_t e, input logic vld,
                                      input logic [IDW-1:0] id, input logic kill);
    entry_t n;
    n = e;
    if (vld && (e.id == id)) begin
      n.cmt  = 1'b1;
      n.kill = e.kill | kill;
    end
    return n;
  endfunction

  cvxif_pkg::x_issue_req_t w_ireq;
  logic [2:0]              w_f3;
  logic [4:0]              w_rd;
  logic                    w_legal;
  logic                    w_wb;
  logic                    w_issue_rdy;
  logic                    w_hs;
  logic                    w_cmt_vld;
  logic [IDW-1:0]          w_cmt_id;
  logic                    w_cmt_kill;
  logic                    w_new_cmt;

  logic                    r_s1_vld;
  entry_t                  r_s1;
  logic [2:0]              r_s1_op;
  logic [XLEN-1:0]         r_s1_a;
  logic [XLEN-1:0]         r_s1_b;
  logic [XLEN-1:0]         r_s1_c;
  logic [XLEN-1:0]         w_res;
  entry_t                  w_push_ent;

  entry_t                  r_fifo [Depth];
  logic [AW-1:0]           r_wptr;
  logic [AW-1:0]           r_rptr;
  logic                    r_wwrap;
  logic                    r_rwrap;
  logic                    w_empty;
  logic [AW:0]             w_cnt;
  logic [OW-1:0]           w_occ;
  entry_t                  w_head;
  logic                    w_res_vld;
  logic                    w_pop;
  logic                    w_unused;

  assign w_ireq     = cvxif_req_i.x_issue_req;
  assign w_f3       = w_ireq.instr[14:12];
  assign w_rd       = w_ireq.instr[11:7];
  assign w_cmt_vld  = cvxif_req_i.x_commit_valid;
  assign w_cmt_id   = cvxif_req_i.x_commit.id;
  assign w_cmt_kill = cvxif_req_i.x_commit.x_commit_kill;

  always_comb begin
    w_legal = 1'b0;
    if (w_ireq.instr[6:0] == OPC_CUSTOM0) begin
      case (w_f3)
        F3_ADD, F3_SUB, F3_XOR: w_legal = &w_ireq.rs_valid[1:0];
        F3_ADD3: w_legal = (CVA6Cfg.X_NUM_RS == 32'd3) && (NRS == 3) && (&w_ireq.rs_valid);
        F3_TRAP: w_legal = 1'b1;
        default: w_legal = 1'b0;
      endcase
    end
  end

  assign w_wb      = w_legal && (w_rd != 5'd0) && (w_f3 != F3_TRAP);
  assign w_new_cmt = w_cmt_vld && (w_cmt_id == w_ireq.id);

  // Pipeline never stalls: the occupancy limit guarantees FIFO room for the operand stage.
  assign w_empty     = (r_wptr == r_rptr) && (r_wwrap == r_rwrap);
  assign w_cnt       = {r_wwrap, r_wptr} - {r_rwrap, r_rptr};
  assign w_occ       = OW'(w_cnt) + OW'(r_s1_vld);
  assign w_issue_rdy = !rst_i && (w_occ < OW'(Depth));
  assign w_hs        = cvxif_req_i.x_issue_valid && w_issue_rdy && w_legal;

  assign w_head    = r_fifo[r_rptr];
  assign w_res_vld = !rst_i && !w_empty && w_head.cmt && !w_head.kill;
  assign w_pop     = !w_empty && (w_head.kill || (w_res_vld && cvxif_req_i.x_result_ready));

  always_comb begin
    w_res = '0;
    case (r_s1_op)
      F3_ADD:  w_res = r_s1_a + r_s1_b;
      F3_SUB:  w_res = r_s1_a - r_s1_b;
      F3_XOR:  w_res = r_s1_a ^ r_s1_b;
      F3_ADD3: w_res = r_s1_a + r_s1_b + r_s1_c;
      default: w_res = '0;
    endcase
  end

  always_comb begin
    w_push_ent      = f_commit(r_s1, w_cmt_vld, w_cmt_id, w_cmt_kill);
    w_push_ent.data = w_res;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_s1_vld <= 1'b0;
      r_s1     <= '0;
      r_s1_op  <= '0;
      r_s1_a   <= '0;
      r_s1_b   <= '0;
      r_s1_c   <= '0;
      r_wptr   <= '0;
      r_rptr   <= '0;
      r_wwrap  <= 1'b0;
      r_rwrap  <= 1'b0;
      for (int unsigned i = 0; i < Depth; i++) r_fifo[AW'(i)] <= '0;
    end else begin
      r_s1_vld <= w_hs;
      if (w_hs) begin
        r_s1.id   <= w_ireq.id;
        r_s1.rd   <= w_rd;
        r_s1.we   <= w_wb;
        r_s1.trap <= (w_f3 == F3_TRAP);
        r_s1.cmt  <= w_new_cmt;
        r_s1.kill <= w_new_cmt && w_cmt_kill;
        r_s1.data <= '0;
        r_s1_op   <= w_f3;
        r_s1_a    <= w_ireq.rs[0];
        r_s1_b    <= w_ireq.rs[1];
        r_s1_c    <= w_ireq.rs[NRS-1];
      end
      for (int unsigned i = 0; i < Depth; i++) begin
        r_fifo[AW'(i)] <= f_commit(r_fifo[AW'(i)], w_cmt_vld, w_cmt_id, w_cmt_kill);
      end
      if (r_s1_vld) begin
        r_fifo[r_wptr]    <= w_push_ent;
        {r_wwrap, r_wptr} <= {r_wwrap, r_wptr} + (AW+1)'(1);
      end
      if (w_pop) {r_rwrap, r_rptr} <= {r_rwrap, r_rptr} + (AW+1)'(1);
    end
  end

  always_comb begin
    cvxif_resp_o                        = '0;
    cvxif_resp_o.x_issue_ready          = w_issue_rdy;
    cvxif_resp_o.x_issue_resp.accept    = w_legal;
    cvxif_resp_o.x_issue_resp.writeback = w_wb;
    cvxif_resp_o.x_result_valid         = w_res_vld;
    if (w_res_vld) begin
      cvxif_resp_o.x_result.id      = w_head.id;
      cvxif_resp_o.x_result.data    = w_head.data;
      cvxif_resp_o.x_result.rd      = w_head.rd;
      cvxif_resp_o.x_result.we      = w_head.we;
      cvxif_resp_o.x_result.exc     = w_head.trap;
      cvxif_resp_o.x_result.exccode = w_head.trap ? 6'd2 : 6'd0;
    end
  end

  // Memory channel is never used by this coprocessor.
  assign w_unused = ^{cvxif_req_i.x_mem_ready, cvxif_req_i.x_mem_resp,
                      cvxif_req_i.x_mem_result_valid, cvxif_req_i.x_mem_result,
                      w_ireq.mode, w_ireq.instr[31:15]};

endmodule

// File: doc/cvxif_copro_resp.md
CVXIF_COPRO_RESP -- requirements
Module: cvxif_copro_resp

Interface
REQ-001 SHALL have parameter CVA6Cfg, default config_pkg::cva6_cfg_empty, CVA6 configuration.
REQ-002 SHALL have parameter Depth, default 4, combined pipeline plus result-FIFO capacity (power of two, >=2).
REQ-003 SHALL have port clk_i  input  1  single clock; all state on rising edge.
REQ-004 SHALL have port rst_i  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port cvxif_req_i  input  cvxif_pkg::cvxif_req_t  issue/commit/result-ready from the core.
REQ-006 SHALL have port cvxif_resp_o  output  cvxif_pkg::cvxif_resp_t  issue-ready/accept/result to the core.

Function
REQ-007 SHALL decode only opcode instr[6:0]=7'b0001011 (custom-0); funct3=instr[14:12], rd=instr[11:7].
REQ-008 SHALL support funct3 000 ADD rs[0]+rs[1]; 001 SUB rs[0]-rs[1]; 010 XOR; 011 ADD3 rs[0]+rs[1]+rs[2] (legal only when X_NUM_RS==3); 111 TRAP.
REQ-009 SHALL compute XLEN-wide results modulo 2^XLEN; overflow is ignored.
REQ-010 SHALL drive x_issue_resp combinationally from x_issue_req in the same cycle: accept=1 only for a legal op whose required rs_valid bits are all 1; otherwise accept=0 and all other x_issue_resp fields 0.
REQ-011 SHALL set, on accept, writeback=(rd!=0 && funct3!=111), and dualwrite, dualread, loadstore, exc all 0.
REQ-012 SHALL drive x_issue_ready=1 iff occupancy (pipeline entries + FIFO entries) < Depth; not combinationally dependent on x_issue_valid.
REQ-013 SHALL treat an issue handshake as x_issue_valid && x_issue_ready && accept; only handshaken instructions enter the pipeline; rejected ones leave no state.
REQ-014 SHALL use a 2-stage execute pipeline: stage 1 captures id, rd, op, operands; stage 2 registers the result; the entry is pushed into the result FIFO at the end of stage 2, so x_result_valid is earliest 2 cycles after the handshake cycle.
REQ-015 SHALL tag each in-flight entry with committed and killed flags; a commit with x_commit_valid=1 and x_commit.id matching sets committed, plus killed if x_commit_kill=1; a commit in the handshake cycle for the same id applies.
REQ-016 SHALL discard killed entries at FIFO head without asserting x_result_valid; the slot frees the next cycle.
REQ-017 SHALL assert x_result_valid only when the FIFO head is committed and not killed; an uncommitted head blocks younger entries (in-order return).
REQ-018 SHALL drive x_result fields from the head: id, data, rd, we=writeback value, exc=1 and exccode=2 (illegal instruction) for TRAP with data=0, else exc=0 and exccode=0.
REQ-019 SHALL pop the head on x_result_valid && x_result_ready; x_result_valid and all x_result fields are held stable while x_result_ready=0.
REQ-020 SHALL allow push and pop in the same cycle with a full FIFO; occupancy then stays constant.
REQ-021 SHALL hold x_mem_valid=0 and all x_mem_req fields 0 at all times; x_mem_ready, x_mem_resp and x_mem_result inputs are ignored.
REQ-022 SHALL use FIFO pointers of clog2(Depth) bits that wrap from Depth-1 to 0 with a separate full/empty bit.

Reset
REQ-023 SHALL, on any clock edge with rst_i=1, empty the pipeline and FIFO and clear all flags, including mid-operation; in-flight results are lost.
REQ-024 SHALL drive, while rst_i=1 and in the cycle it is sampled, x_issue_ready=0, x_result_valid=0, x_result=0 and x_mem_valid=0.
REQ-025 SHALL drive x_issue_ready=1 in the first cycle after rst_i deasserts.

Verification
REQ-026 SHALL cover: ADD id=2 rd=3 rs0=5 rs1=7, commit kill=0 in the same cycle -> accept=1, writeback=1; 2 cycles later x_result_valid=1, data=12, rd=3, we=1, id=2.
REQ-027 SHALL cover: instr opcode 7'b0110011 -> accept=0, writeback=0; no x_result_valid ever; occupancy unchanged.
REQ-028 SHALL cover: 5 back-to-back ADDs with x_result_ready=0, Depth=4 -> 4 accepted, then x_issue_ready=0; after ready=1, results return in id order, x_issue_ready=1 the cycle after the first pop.
REQ-029 SHALL cover: SUB id=5 rs0=0 rs1=1 with commit kill=1 -> no result for id 5; a following XOR id=6 returns in its normal slot with data=rs0^rs1.
REQ-030 SHALL cover: TRAP id=1 rd=4 -> writeback=0; result exc=1, exccode=2, we=0, data=0; ADD with rd=0 -> we=0.
REQ-031 SHALL cover: rst_i=1 for one cycle with 3 entries in flight -> x_result_valid=0 next cycle, no stale results; x_issue_ready=1 the cycle after release.
